serial_pattern_tx: RTL and testbench

- Serial bit-pattern transmitter: the source end of the serial bit stream consumed by the codebase's Moore sequence detectors (e.g. the 1101 detector).
- Latches a programmable pattern, emits it MSB-first one bit per clock, repeats it N times with an optional idle gap, then pulses done.
- Used as stimulus driver and as an on-chip sync/preamble generator.

---
 rtl/serial_pattern_tx.sv | 163 ++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - serial bit-pattern transmitter, MSB-first, N repetitions with optional gap
module serial_pattern_tx #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   reps,
  input  logic [GAP_W-1:0]   gap,
  output logic               out,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    GAP  = ST_GAP,
    DONE = ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  logic               out_q, out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [LEN_W-1:0]   len_clamp;
  logic [MAX_LEN-1:0] shifted;
  logic               emit;

  assign len_clamp = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
    out_d     = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    emit      = 1'b0;
    shifted   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pattern_d = pattern;
          len_d     = len_clamp;
          rep_d     = reps;
          gap_d     = gap;
          if (len_clamp == LEN_W'(0) || reps == CNT_W'(0)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SEND;
            idx_d   = len_clamp - LEN_W'(1);
            emit    = 1'b1;
          end
        end
      end
      SEND: begin
        // idx_q is the bit currently on out; pick the bit for the next cycle
        if (idx_q != LEN_W'(0)) begin
          idx_d = idx_q - LEN_W'(1);
          emit  = 1'b1;
        end else if (rep_q > CNT_W'(1)) begin
          rep_d = rep_q - CNT_W'(1);
          if (gap_q != GAP_W'(0)) begin
            state_d = GAP;
            gcnt_d  = gap_q;
            busy_d  = 1'b1;
          end else begin
            idx_d = len_q - LEN_W'(1);
            emit  = 1'b1;
          end
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (gcnt_q <= GAP_W'(1)) begin
          state_d = SEND;
          gcnt_d  = '0;
          idx_d   = len_q - LEN_W'(1);
          emit    = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (emit) begin
      shifted = pattern_d >> idx_d;
      out_d   = shifted[0];
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gcnt_q    <= '0;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gcnt_q    <= gcnt_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - scoreboard bench for serial_pattern_tx
module tb_serial_pattern_tx;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [7:0]  reps;
  logic [3:0]  gap;
  logic        out;
  logic        valid;
  logic        busy;
  logic        done;

  serial_pattern_tx dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .gap     (gap),
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic o;
    logic v;
    logic b;
    logic d;
  } exp_t;

  exp_t sbq[$];
  int   total;
  int   passed;
  int   failed;
  int   cyc;
  int   vcnt;
  int   done_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_idle();
    sbq.push_back(4'b0000);
  endtask

  // Expected per-cycle outputs, starting the cycle after the start edge.
  task automatic push_xfer(input logic [15:0] p, input int l, input int r, input int g);
    int lc;
    lc = (l > 16) ? 16 : l;
    if (lc == 0 || r == 0) begin
      sbq.push_back(4'b0001);
      return;
    end
    for (int rr = 0; rr < r; rr++) begin
      for (int k = lc - 1; k >= 0; k--) sbq.push_back({p[k], 3'b110});
      if (rr < r - 1)
        for (int gg = 0; gg < g; gg++) sbq.push_back(4'b0010);
    end
    sbq.push_back(4'b0001);
  endtask

  // Called just after a negedge; applies start for one edge then scrambles inputs.
  task automatic pulse_start(input logic [15:0] p, input int l, input int r, input int g);
    pattern = p;
    len     = 5'(l);
    reps    = 8'(r);
    gap     = 4'(g);
    start   = 1'b1;
    cyc     = 0;
    vcnt    = 0;
    done_at = -1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    pattern = 16'($urandom);
    len     = 5'($urandom);
    reps    = 8'($urandom);
    gap     = 4'($urandom);
  endtask

  task automatic drain(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (sbq.size() == 0) begin
        chk($sformatf("%s_sb_empty", tag), 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("%s_c%0d_out", tag, cyc), 32'(out), 32'(e.o));
        chk($sformatf("%s_c%0d_valid", tag, cyc), 32'(valid), 32'(e.v));
        chk($sformatf("%s_c%0d_busy", tag, cyc), 32'(busy), 32'(e.b));
        chk($sformatf("%s_c%0d_done", tag, cyc), 32'(done), 32'(e.d));
      end
      if (valid) vcnt++;
      if (done && done_at < 0) done_at = cyc;
    end
  endtask

  task automatic totals(input string tag, input int l, input int r, input int g);
    int lc;
    int expd;
    lc   = (l > 16) ? 16 : l;
    expd = (lc == 0 || r == 0) ? 1 : r * lc + (r - 1) * g + 1;
    chk($sformatf("%s_valid_count", tag), 32'(vcnt), 32'((lc == 0 || r == 0) ? 0 : r * lc));
    chk($sformatf("%s_done_cycle", tag), 32'(done_at), 32'(expd));
  endtask

  task automatic xfer(input string tag, input logic [15:0] p, input int l, input int r, input int g);
    push_xfer(p, l, r, g);
    push_idle();
    pulse_start(p, l, r, g);
    drain(tag, sbq.size());
    totals(tag, l, r, g);
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    failed  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    pattern = '0;
    len     = '0;
    reps    = '0;
    gap     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    xfer("t1", 16'h000D, 4, 1, 0);
    xfer("t2", 16'h000D, 4, 2, 0);
    xfer("t3", 16'h000D, 4, 3, 2);
    xfer("t4a", 16'h000D, 0, 5, 0);
    xfer("t4b", 16'h000D, 4, 0, 0);
    xfer("t6b", 16'hA5C3, 20, 1, 0);
    xfer("t7", 16'h0001, 1, 255, 0);
    xfer("t8", 16'h0B2D, 12, 2, 1);

    // start re-pulsed mid-transfer with a different request
    push_xfer(16'h0039, 6, 2, 3);
    push_idle();
    pulse_start(16'h0039, 6, 2, 3);
    drain("t5a", 2);
    pattern = 16'hFFFF;
    len     = 5'd8;
    reps    = 8'd3;
    gap     = 4'd0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("t5a", 7);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("t5a", sbq.size());
    totals("t5a", 6, 2, 3);

    // start held through DONE: second request latched from the IDLE cycle after done
    push_xfer(16'h000B, 4, 1, 0);
    push_idle();
    push_xfer(16'h0006, 3, 1, 0);
    push_idle();
    pulse_start(16'h000B, 4, 1, 0);
    start   = 1'b1;
    pattern = 16'h0006;
    len     = 5'd3;
    reps    = 8'd1;
    gap     = 4'd0;
    drain("t5b", 6);
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("t5b", sbq.size());

    // reset at the 3rd bit of a reps=2 transfer, with start asserted alongside
    push_xfer(16'h000D, 4, 2, 0);
    pulse_start(16'h000D, 4, 2, 0);
    drain("t6a", 3);
    sbq.delete();
    reset   = 1'b1;
    start   = 1'b1;
    pattern = 16'h000F;
    len     = 5'd4;
    reps    = 8'd1;
    push_idle();
    drain("t6a_rst", 1);
    reset = 1'b0;
    start = 1'b0;
    push_idle();
    push_idle();
    drain("t6a_post", 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
